// File: rtl/gm_line_fetch.sv
// gm_line_fetch: scanline fetch engine for the graphics-mode pipeline.
//
// Reads one scanline of packed indexed pixels (1/2/4/8 bpp) over a pipelined
// Wishbone master, expands pixels through a 256-entry palette or to grayscale,
// and pushes 4-pixel RGB groups to the clock-crossing FIFO with backpressure.
//
// Optional feature macro: GM_LINE_DOUBLE_EN -- each line is fetched twice
// (line address advances every second completed line) for 2x vertical scaling.
//
// Ports:
//   clk_i, rst_i        clock, synchronous active-high reset
//   frame_start         reload line address from base_adr (deferred while busy)
//   line_start          fetch the next line; ignored (and overrun set) while busy
//   base_adr            framebuffer byte address of line 0
//   bpp_sel             0=8, 1=4, 2=2, 3=1 bpp; sampled at line_start
//   color               1 = palette lookup, 0 = grayscale
//   out_valid/ready/data  output group handshake, {pix0..pix3}, pix0 in [95:72]
//   busy, overrun       bus phase active; sticky line_start-while-busy flag
//   bus_*               Wishbone master (framebuffer reads)
//   palette_*           Wishbone slave (palette read/write)
module gm_line_fetch #(
  parameter int unsigned LINE_PIXELS = 640,
  parameter int unsigned MAX_OUT     = 4,
  parameter int unsigned ADR_W       = 32
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             frame_start,
  input  logic             line_start,
  input  logic [ADR_W-1:0] base_adr,
  input  logic [1:0]       bpp_sel,
  input  logic             color,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [95:0]      out_data,
  output logic             busy,
  output logic             overrun,
  // framebuffer bus (master)
  output logic             bus_cyc,
  output logic             bus_stb,
  output logic             bus_we,
  output logic [3:0]       bus_sel,
  output logic [ADR_W-1:0] bus_adr,
  output logic [31:0]      bus_dat_o,
  input  logic [31:0]      bus_dat_i,
  input  logic             bus_ack,
  input  logic             bus_stall,
  // palette bus (slave)
  input  logic             palette_cyc,
  input  logic             palette_stb,
  input  logic             palette_we,
  input  logic [ADR_W-1:0] palette_adr,
  input  logic [3:0]       palette_sel,
  input  logic [31:0]      palette_dat_i,
  output logic [31:0]      palette_dat_o,
  output logic             palette_ack,
  output logic             palette_stall
);

  localparam int unsigned WplMax = LINE_PIXELS / 4;  // words per line at 8 bpp
  localparam int unsigned CW     = $clog2(WplMax + 1);
  localparam int unsigned PW     = (MAX_OUT > 1) ? $clog2(MAX_OUT) : 1;
  localparam int unsigned NW     = $clog2(MAX_OUT + 1);

  typedef enum logic [1:0] {S_IDLE, S_FETCH, S_DRAIN} state_e;

  state_e           state_q;
  logic [CW-1:0]    issued_q, acked_q, wpl;
  logic [ADR_W-1:0] line_adr_q, line_bytes;
  logic [1:0]       bpp_q;
  logic             reload_q, overrun_q;
`ifdef GM_LINE_DOUBLE_EN
  logic             parity_q;
`endif

  logic [31:0]      wbuf [MAX_OUT];
  logic [PW-1:0]    rd_ptr_q, wr_ptr_q;
  logic [NW-1:0]    count_q;
  logic [2:0]       gidx_q, gidx_last;
  logic             out_valid_q;
  logic [95:0]      out_data_q;

  logic [23:0]      pal_mem [4][256];
  logic [31:0]      pal_rdata_q;
  logic             pal_ack_q;

  logic start, credit, req_acc, ack_acc, line_done, load, pop;

  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (p == PW'(MAX_OUT - 1)) ? '0 : p + PW'(1);
  endfunction

  assign wpl        = CW'(WplMax >> bpp_q);
  assign line_bytes = ADR_W'(wpl) << 2;
  assign start      = (state_q == S_IDLE) && line_start;
  // Outstanding requests plus buffered words (including the word being unpacked).
  assign credit     = (32'(issued_q) - 32'(acked_q) + 32'(count_q)) < MAX_OUT;

  assign bus_cyc   = (state_q != S_IDLE);
  assign bus_stb   = (state_q == S_FETCH) && (issued_q < wpl) && credit;
  assign bus_adr   = line_adr_q + (ADR_W'(issued_q) << 2);
  assign bus_we    = 1'b0;
  assign bus_sel   = 4'hF;
  assign bus_dat_o = 32'h0;
  assign busy      = (state_q != S_IDLE);
  assign overrun   = overrun_q;
  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;

  assign req_acc   = bus_stb && !bus_stall;
  assign ack_acc   = bus_ack && (state_q != S_IDLE);  // late acks after reset are dropped
  assign line_done = (state_q == S_DRAIN) && ((acked_q + CW'(ack_acc)) == wpl);

  assign gidx_last = (3'd1 << bpp_q) - 3'd1;
  assign load      = (count_q != '0) && (!out_valid_q || out_ready);
  assign pop       = load && (gidx_q == gidx_last);

  // Group extraction: shift the current group to the top, then slice 4 pixels.
  logic [31:0] head, shifted;
  logic [4:0]  shamt;
  logic [7:0]  idx  [4];
  logic [7:0]  gray [4];
  logic [95:0] group;

  always_comb begin
    head    = wbuf[rd_ptr_q];
    shamt   = 5'(gidx_q) << (3'd5 - {1'b0, bpp_q});
    shifted = head << shamt;
    group   = '0;
    for (int k = 0; k < 4; k++) begin
      idx[k]  = '0;
      gray[k] = '0;
      case (bpp_q)
        2'd0: begin
          idx[k]  = shifted[31-8*k -: 8];
          gray[k] = shifted[31-8*k -: 8];
        end
        2'd1: begin
          idx[k]  = {4'h0, shifted[31-4*k -: 4]};
          gray[k] = {2{shifted[31-4*k -: 4]}};
        end
        2'd2: begin
          idx[k]  = {6'h0, shifted[31-2*k -: 2]};
          gray[k] = {4{shifted[31-2*k -: 2]}};
        end
        default: begin
          idx[k]  = {7'h0, shifted[31-k]};
          gray[k] = {8{shifted[31-k]}};
        end
      endcase
      group[95-24*k -: 24] = color ? pal_mem[k][idx[k]] : {3{gray[k]}};
    end
  end

  always_ff @(posedge clk_i) begin
    if (ack_acc) wbuf[wr_ptr_q] <= bus_dat_i;
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q     <= S_IDLE;
      issued_q    <= '0;
      acked_q     <= '0;
      line_adr_q  <= '0;
      bpp_q       <= '0;
      reload_q    <= 1'b0;
      overrun_q   <= 1'b0;
`ifdef GM_LINE_DOUBLE_EN
      parity_q    <= 1'b0;
`endif
      rd_ptr_q    <= '0;
      wr_ptr_q    <= '0;
      count_q     <= '0;
      gidx_q      <= '0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
    end else begin
      if (load) begin
        out_data_q  <= group;
        out_valid_q <= 1'b1;
      end else if (out_ready) begin
        out_valid_q <= 1'b0;
      end

      if (start) begin
        rd_ptr_q <= '0;
        wr_ptr_q <= '0;
        count_q  <= '0;
        gidx_q   <= '0;
      end else begin
        if (ack_acc) wr_ptr_q <= ptr_inc(wr_ptr_q);
        if (pop)     rd_ptr_q <= ptr_inc(rd_ptr_q);
        if (load)    gidx_q   <= pop ? 3'd0 : gidx_q + 3'd1;
        count_q <= count_q + NW'(ack_acc) - NW'(pop);
      end

      if (frame_start) overrun_q <= 1'b0;
      if (line_start && state_q != S_IDLE) overrun_q <= 1'b1;

      case (state_q)
        S_IDLE: begin
          if (frame_start) begin
            line_adr_q <= base_adr;
            reload_q   <= 1'b0;
`ifdef GM_LINE_DOUBLE_EN
            parity_q   <= 1'b0;
`endif
          end
          if (line_start) begin
            state_q  <= S_FETCH;
            issued_q <= '0;
            acked_q  <= '0;
            bpp_q    <= bpp_sel;
          end
        end
        S_FETCH: begin
          if (frame_start) reload_q <= 1'b1;
          if (req_acc)     issued_q <= issued_q + CW'(1);
          if (ack_acc)     acked_q  <= acked_q + CW'(1);
          if (req_acc && (issued_q + CW'(1)) == wpl) state_q <= S_DRAIN;
        end
        S_DRAIN: begin
          if (frame_start) reload_q <= 1'b1;
          if (ack_acc)     acked_q  <= acked_q + CW'(1);
          if (line_done) begin
            state_q  <= S_IDLE;
            reload_q <= 1'b0;
            if (reload_q || frame_start) begin
              line_adr_q <= base_adr;
`ifdef GM_LINE_DOUBLE_EN
              parity_q   <= 1'b0;
`endif
            end else begin
`ifdef GM_LINE_DOUBLE_EN
              parity_q <= ~parity_q;
              if (parity_q) line_adr_q <= line_adr_q + line_bytes;
`else
              line_adr_q <= line_adr_q + line_bytes;
`endif
            end
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  // Palette: four read copies (one per pixel lane) behind one write port.
  logic       pal_req, pal_wr;
  logic [7:0] pidx;
  assign pal_req = palette_cyc && palette_stb;
  assign pal_wr  = pal_req && palette_we;
  assign pidx    = palette_adr[9:2];

  always_ff @(posedge clk_i) begin
    if (pal_wr) begin
      for (int c = 0; c < 4; c++) begin
        if (palette_sel[2]) pal_mem[c][pidx][23:16] <= palette_dat_i[23:16];
        if (palette_sel[1]) pal_mem[c][pidx][15:8]  <= palette_dat_i[15:8];
        if (palette_sel[0]) pal_mem[c][pidx][7:0]   <= palette_dat_i[7:0];
      end
    end
    if (pal_req && !palette_we) pal_rdata_q <= {8'h0, pal_mem[0][pidx]};
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) pal_ack_q <= 1'b0;
    else       pal_ack_q <= pal_req;
  end

  assign palette_dat_o = pal_rdata_q;
  assign palette_ack   = pal_ack_q;
  assign palette_stall = 1'b0;

  logic unused_pal;
  assign unused_pal = ^{palette_adr[ADR_W-1:10], palette_adr[1:0], palette_dat_i[31:24],
                        palette_sel[3]};

endmodule
